// File: rtl/ws_array_ctrl.sv
// Job sequencer for the weight-stationary systolic array: weight load, activation streaming and
// result tagging. Buffers have 1-cycle read latency; every output is registered.
module ws_array_ctrl #(
   parameter int unsigned size       = 16,
   parameter int unsigned addr_width = 16,
   parameter int unsigned drain_lat  = 2 * size
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic [addr_width-1:0]   num_vectors_i,
   input  logic                    reuse_weights_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    weights_loaded_o,
   output logic                    wt_rd_en_o,
   output logic [$clog2(size)-1:0] wt_rd_addr_o,
   output logic                    sa_control_o,
   output logic                    act_rd_en_o,
   output logic [addr_width-1:0]   act_rd_addr_o,
   output logic                    out_valid_o,
   output logic [addr_width-1:0]   out_addr_o
);

   localparam int unsigned WtAw = $clog2(size);
   localparam int unsigned LdW  = $clog2(size + 1);
   localparam int unsigned CntW = addr_width + 1;
   localparam logic [LdW-1:0]  LdLast = LdW'(size - 1);
   localparam logic [LdW-1:0]  LdEnd  = LdW'(size);
   localparam logic [CntW-1:0] CntOne = CntW'(1);
   localparam logic [WtAw-1:0] WtTop  = WtAw'(size - 1);

   typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

   state_e                state_q, state_d;
   logic [LdW-1:0]        ld_cnt_q, ld_cnt_d;
   logic [CntW-1:0]       act_cnt_q, act_cnt_d;
   logic [CntW-1:0]       res_cnt_q;
   logic [CntW-1:0]       num_q, num_d;
   logic [drain_lat-1:0]  pipe_q;

   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  wl_q;
   logic                  wt_rd_en_q, wt_rd_en_d;
   logic [WtAw-1:0]       wt_rd_addr_q, wt_rd_addr_d;
   logic                  sa_control_q;
   logic                  act_rd_en_q, act_rd_en_d;
   logic [addr_width-1:0] act_rd_addr_q, act_rd_addr_d;
   logic                  out_valid_q;
   logic [addr_width-1:0] out_addr_q;

   always_comb begin
      state_d       = state_q;
      ld_cnt_d      = ld_cnt_q;
      act_cnt_d     = act_cnt_q;
      num_d         = num_q;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      wt_rd_en_d    = 1'b0;
      wt_rd_addr_d  = '0;
      act_rd_en_d   = 1'b0;
      act_rd_addr_d = '0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               num_d     = {1'b0, num_vectors_i};
               ld_cnt_d  = '0;
               act_cnt_d = '0;
               if (!reuse_weights_i || !wl_q) begin
                  state_d = StLoadW;
               end else if (num_vectors_i != '0) begin
                  state_d = StStream;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StLoadW: begin
            busy_d   = 1'b1;
            ld_cnt_d = ld_cnt_q + LdW'(1);
            if (ld_cnt_q != LdEnd) begin
               wt_rd_en_d   = 1'b1;
               wt_rd_addr_d = WtTop - ld_cnt_q[WtAw-1:0];
            end
            // With no vectors, wait one extra cycle so the last weight shift completes.
            if (ld_cnt_q == LdLast && num_q != '0) begin
               state_d = StStream;
            end else if (ld_cnt_q == LdEnd) begin
               state_d = StDone;
            end
         end
         StStream: begin
            busy_d        = 1'b1;
            act_rd_en_d   = 1'b1;
            act_rd_addr_d = act_cnt_q[addr_width-1:0];
            act_cnt_d     = act_cnt_q + CntOne;
            if (act_cnt_q == num_q - CntOne) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            busy_d = 1'b1;
            if (pipe_q[drain_lat-1] && res_cnt_q == num_q - CntOne) begin
               state_d = StDone;
            end
         end
         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= StIdle;
         ld_cnt_q      <= '0;
         act_cnt_q     <= '0;
         res_cnt_q     <= '0;
         num_q         <= '0;
         pipe_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         wl_q          <= 1'b0;
         wt_rd_en_q    <= 1'b0;
         wt_rd_addr_q  <= '0;
         sa_control_q  <= 1'b0;
         act_rd_en_q   <= 1'b0;
         act_rd_addr_q <= '0;
         out_valid_q   <= 1'b0;
         out_addr_q    <= '0;
      end else begin
         state_q       <= state_d;
         ld_cnt_q      <= ld_cnt_d;
         act_cnt_q     <= act_cnt_d;
         num_q         <= num_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         wt_rd_en_q    <= wt_rd_en_d;
         wt_rd_addr_q  <= wt_rd_addr_d;
         sa_control_q  <= wt_rd_en_q;
         act_rd_en_q   <= act_rd_en_d;
         act_rd_addr_q <= act_rd_addr_d;
         // Delayed read strobe; the result index advances on its own counter.
         pipe_q        <= {pipe_q[drain_lat-2:0], act_rd_en_q};
         out_valid_q   <= pipe_q[drain_lat-1];
         if (state_q == StIdle && start_i) begin
            res_cnt_q <= '0;
         end
         if (pipe_q[drain_lat-1]) begin
            out_addr_q <= res_cnt_q[addr_width-1:0];
            res_cnt_q  <= res_cnt_q + CntOne;
         end
         if (state_q == StLoadW && ld_cnt_q == '0) begin
            wl_q <= 1'b0;
         end else if (sa_control_q && !wt_rd_en_q) begin
            wl_q <= 1'b1;
         end
      end
   end

   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign weights_loaded_o = wl_q;
   assign wt_rd_en_o       = wt_rd_en_q;
   assign wt_rd_addr_o     = wt_rd_addr_q;
   assign sa_control_o     = sa_control_q;
   assign act_rd_en_o      = act_rd_en_q;
   assign act_rd_addr_o    = act_rd_addr_q;
   assign out_valid_o      = out_valid_q;
   assign out_addr_o       = out_addr_q;

endmodule

// File: tb/tb_ws_array_ctrl.sv
// Bench for ws_array_ctrl: per-cycle output traces compared against a timing model computed
// directly from cycle arithmetic relative to the start-accept edge.
module tb_ws_array_ctrl;

   localparam int SIZE   = 4;
   localparam int AW     = 6;
   localparam int DRAIN  = 8;
   localparam int WA     = $clog2(SIZE);
   localparam int PW     = 9 + 2 * AW;
   localparam int MAXLEN = 128;

   logic          clk;
   logic          rst;
   logic          start;
   logic [AW-1:0] num;
   logic          reuse_w;
   logic          busy, done, wl, wt_en, sa, act_en, ov;
   logic [WA-1:0] wt_addr;
   logic [AW-1:0] act_addr, out_addr;

   int checks = 0;
   int errors = 0;
   bit wl_m;
   logic [PW-1:0] obs [MAXLEN];

   ws_array_ctrl #(
      .size      (SIZE),
      .addr_width(AW),
      .drain_lat (DRAIN)
   ) dut (
      .clk_i           (clk),
      .reset_i         (rst),
      .start_i         (start),
      .num_vectors_i   (num),
      .reuse_weights_i (reuse_w),
      .busy_o          (busy),
      .done_o          (done),
      .weights_loaded_o(wl),
      .wt_rd_en_o      (wt_en),
      .wt_rd_addr_o    (wt_addr),
      .sa_control_o    (sa),
      .act_rd_en_o     (act_en),
      .act_rd_addr_o   (act_addr),
      .out_valid_o     (ov),
      .out_addr_o      (out_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs c cycles after the accept edge of one job; addresses are 0 when not strobed.
   function automatic logic [PW-1:0] model(input int c, input int n, input bit load,
                                           input bit wl0);
      int base, last_busy, wt_a, act_a, out_a;
      bit b, d, w, we, s, ae, v;
      base = load ? SIZE : 0;
      if (n > 0) last_busy = base + n + 1 + DRAIN;
      else       last_busy = load ? SIZE + 1 : 0;
      b     = (c >= 1) && (c <= last_busy);
      d     = (c == last_busy + 1);
      we    = load && (c >= 1) && (c <= SIZE);
      wt_a  = we ? SIZE - c : 0;
      s     = load && (c >= 2) && (c <= SIZE + 1);
      w     = load ? ((c == 0) ? wl0 : (c >= SIZE + 2)) : wl0;
      ae    = (c >= base + 1) && (c <= base + n);
      act_a = ae ? c - base - 1 : 0;
      v     = (c >= base + 2 + DRAIN) && (c <= base + n + 1 + DRAIN);
      out_a = v ? c - base - 2 - DRAIN : 0;
      return {b, d, w, we, WA'(wt_a), s, ae, AW'(act_a), v, AW'(out_a)};
   endfunction

   function automatic logic [PW-1:0] pack_obs();
      return {busy, done, wl, wt_en, wt_addr & {WA{wt_en}}, sa, act_en,
              act_addr & {AW{act_en}}, ov, out_addr & {AW{ov}}};
   endfunction

   // Start a job accepted at edge 0 and record cycles 0..len-1; later inputs take n2/reuse2.
   task automatic run_trace(input int len, input int n, input bit reuse, input int n2,
                            input bit reuse2, input int sp1, input int sp2, input int rst_cyc);
      start   = 1'b1;
      num     = AW'(n);
      reuse_w = reuse;
      for (int k = 0; k < len; k++) begin
         @(posedge clk);
         #1;
         obs[k]  = pack_obs();
         start   = (k + 1 == sp1) || (k + 1 == sp2);
         num     = AW'(n2);
         reuse_w = reuse2;
         rst     = (k == rst_cyc);
      end
      start = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (pack_obs() !== '0) begin
            errors++;
            $display("FAIL reset_hold %0d: got %h expected 0", i, pack_obs());
         end
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (pack_obs() !== '0) begin
         errors++;
         $display("FAIL reset_idle: got %h expected 0", pack_obs());
      end
      wl_m = 1'b0;
   endtask

   task automatic test_forced_load();
      run_trace(20, 3, 1'b1, 3, 1'b1, -1, -1, -1);
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (obs[k] !== model(k, 3, 1'b1, wl_m)) begin
            errors++;
            $display("FAIL forced_load cycle %0d: got %h expected %h", k, obs[k],
                     model(k, 3, 1'b1, wl_m));
         end
      end
      wl_m = 1'b1;
   endtask

   task automatic test_full_job();
      run_trace(20, 3, 1'b0, 5, 1'b1, -1, -1, -1);
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (obs[k] !== model(k, 3, 1'b1, wl_m)) begin
            errors++;
            $display("FAIL full_job cycle %0d: got %h expected %h", k, obs[k],
                     model(k, 3, 1'b1, wl_m));
         end
      end
      wl_m = 1'b1;
   endtask

   task automatic test_reuse();
      run_trace(16, 3, 1'b1, 0, 1'b0, -1, -1, -1);
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (obs[k] !== model(k, 3, 1'b0, wl_m)) begin
            errors++;
            $display("FAIL reuse cycle %0d: got %h expected %h", k, obs[k],
                     model(k, 3, 1'b0, wl_m));
         end
      end
   endtask

   task automatic test_n_zero();
      run_trace(4, 0, 1'b1, 2, 1'b0, -1, -1, -1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== model(k, 0, 1'b0, wl_m)) begin
            errors++;
            $display("FAIL n0_reuse cycle %0d: got %h expected %h", k, obs[k],
                     model(k, 0, 1'b0, wl_m));
         end
      end
      run_trace(9, 0, 1'b0, 2, 1'b1, -1, -1, -1);
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (obs[k] !== model(k, 0, 1'b1, wl_m)) begin
            errors++;
            $display("FAIL n0_load cycle %0d: got %h expected %h", k, obs[k],
                     model(k, 0, 1'b1, wl_m));
         end
      end
      wl_m = 1'b1;
   endtask

   task automatic test_start_ignored();
      run_trace(20, 3, 1'b0, int'($urandom_range(1, 7)), 1'b1, 3, 10, -1);
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (obs[k] !== model(k, 3, 1'b1, wl_m)) begin
            errors++;
            $display("FAIL start_ignored cycle %0d: got %h expected %h", k, obs[k],
                     model(k, 3, 1'b1, wl_m));
         end
      end
      wl_m = 1'b1;
   endtask

   task automatic test_reset_midjob();
      logic [PW-1:0] e;
      run_trace(30, 3, 1'b0, 3, 1'b1, 9, -1, 6);
      for (int k = 0; k < 30; k++) begin
         if (k <= 6)      e = model(k, 3, 1'b1, wl_m);
         else if (k < 9)  e = '0;
         else             e = model(k - 9, 3, 1'b1, 1'b0);
         checks++;
         if (obs[k] !== e) begin
            errors++;
            $display("FAIL reset_midjob cycle %0d: got %h expected %h", k, obs[k], e);
         end
      end
      wl_m = 1'b1;
   endtask

   task automatic test_reset_with_start();
      rst     = 1'b1;
      start   = 1'b1;
      num     = AW'(2);
      reuse_w = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (pack_obs() !== '0) begin
            errors++;
            $display("FAIL reset_with_start cycle %0d: got %h expected 0", k, pack_obs());
         end
         @(posedge clk);
         #1;
      end
      wl_m = 1'b0;
   endtask

   task automatic test_back_to_back();
      int  n2, len;
      bit  r2, load2;
      logic [PW-1:0] e;
      n2    = int'($urandom_range(0, 4));
      r2    = 1'b1;
      load2 = !r2 || 1'b0;
      len   = 18 + SIZE + n2 + DRAIN + 4;
      run_trace(len, 3, 1'b0, n2, r2, 17, 18, -1);
      for (int k = 0; k < len; k++) begin
         e = (k < 18) ? model(k, 3, 1'b1, wl_m) : model(k - 18, n2, load2, 1'b1);
         checks++;
         if (obs[k] !== e) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h", k, obs[k], e);
         end
      end
      wl_m = 1'b1;
   endtask

   task automatic test_random();
      int n, len;
      bit r, load;
      for (int j = 0; j < 8; j++) begin
         n    = int'($urandom_range(0, 7));
         r    = 1'($urandom_range(0, 1));
         load = !r || !wl_m;
         len  = (n > 0) ? (load ? SIZE : 0) + n + DRAIN + 4 : (load ? SIZE + 4 : 3);
         run_trace(len, n, r, int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), -1, -1, -1);
         for (int k = 0; k < len; k++) begin
            checks++;
            if (obs[k] !== model(k, n, load, wl_m)) begin
               errors++;
               $display("FAIL random job %0d cycle %0d: got %h expected %h", j, k, obs[k],
                        model(k, n, load, wl_m));
            end
         end
         if (load) wl_m = 1'b1;
      end
   endtask

   task automatic test_max_n();
      int len;
      len = 63 + DRAIN + 4;
      run_trace(len, 63, 1'b1, 1, 1'b0, -1, -1, -1);
      for (int k = 0; k < len; k++) begin
         checks++;
         if (obs[k] !== model(k, 63, !wl_m, wl_m)) begin
            errors++;
            $display("FAIL max_n cycle %0d: got %h expected %h", k, obs[k],
                     model(k, 63, !wl_m, wl_m));
         end
      end
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      num     = '0;
      reuse_w = 1'b0;
      wl_m    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_forced_load();
      test_reuse();
      test_full_job();
      test_n_zero();
      test_start_ignored();
      test_reset_midjob();
      test_back_to_back();
      test_reset_with_start();
      test_random();
      test_max_n();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ws_array_ctrl.md
# ws_array_ctrl

Sequencer for the weight-stationary systolic array: one `start` runs one full job. A job loads `size` weight rows (unless resident weights are reused), streams `num_vectors` activation vectors, and flags each deskewed result row as it leaves the array bottom. It sits between the weight/activation buffers, which have a fixed 1-cycle read latency, and the array's `control` pin. It owns all job-level timing, so buffers and the array carry no state machine of their own.

## Interface
Parameters:
- `size`, 16: array dimension (rows = columns).
- `addr_width`, 16: activation/result index width.
- `drain_lat`, 2*size: cycles from an activation word entering the array until its deskewed result row is valid at the output.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE.
- `num_vectors`  in  addr_width  activation vector count N; latched on accepted start; 0 is legal.
- `reuse_weights`  in  1  skip the weight load; latched on accepted start.
- `busy`  out  1  job in progress.
- `done`  out  1  1-cycle pulse at job end.
- `weights_loaded`  out  1  array holds a complete weight set.
- `wt_rd_en`  out  1  weight buffer read strobe.
- `wt_rd_addr`  out  $clog2(size)  weight row index.
- `sa_control`  out  1  drives array `control`; 1 = weight shift.
- `act_rd_en`  out  1  activation buffer read strobe.
- `act_rd_addr`  out  addr_width  activation vector index.
- `out_valid`  out  1  result row at the array bottom is valid.
- `out_addr`  out  addr_width  index of the current result row.

## Operation
- All outputs are registered. Reset value of every output is 0, and the FSM returns to IDLE.
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE -> LOAD_W on `start` when `reuse_weights`=0 or `weights_loaded`=0. A reuse request without resident weights is forced to load.
- IDLE -> STREAM on `start` with effective reuse and N>0.
- IDLE -> DONE on `start` with effective reuse and N=0.
- LOAD_W, `size` cycles:
  - `wt_rd_en`=1 with `wt_rd_addr` = size-1 down to 0, so the bottom row is fetched first.
  - `sa_control` is the 1-cycle-delayed `wt_rd_en`, aligned with buffer data.
  - `weights_loaded` clears on entry and sets in the cycle after the last `sa_control`=1.
  - Exit: to STREAM if N>0, else to DONE once the last `sa_control` cycle is over.
- STREAM, N cycles:
  - `act_rd_en`=1 with `act_rd_addr` = 0..N-1; `sa_control`=0.
  - The first activation reaches the array exactly one cycle after the last `sa_control`=1; there is no bubble and no overlap.
- DRAIN:
  - For each `act_rd_en` cycle a, `out_valid`=1 at cycle a+1+drain_lat, with `out_addr` equal to that read's index.
  - Implement with a delayed-strobe counter: the result index counts independently of the read index.
- DONE: `done`=1 for one cycle, then IDLE. `busy` is 0 in the DONE cycle.
- `busy`=1 from the cycle after accepted start through the last `out_valid` (or last `sa_control`).
- `start` while not in IDLE is ignored. Input changes after acceptance are ignored.
- `reset` and `start` in the same cycle: reset wins and the start is dropped.
- Reset mid-job aborts immediately. `weights_loaded` clears, because a partial shift leaves the array content undefined.
- N = 2^addr_width - 1 must run without counter overflow. Counters are addr_width+1 bits wide where needed.

## Timing
- Cycle 0 is the edge where `start` is accepted. Load path, cycle by cycle:
  - `wt_rd_en` high in cycles 1..size.
  - `sa_control` high in cycles 2..size+1.
  - `act_rd_en` high in cycles size+1..size+N, so activation data is at the array in cycles size+2..size+N+1.
- Reuse path: `act_rd_en` high in cycles 1..N.
- Result latency is 1 + drain_lat cycles after each read. Results come out in order and back-to-back.
- End of job:
  - `done` is 1 cycle after the last `out_valid`.
  - With N=0 and a load, `done` is at cycle size+2.
  - With N=0 and reuse, `done` is at cycle 1 and `busy` never rises.
- Back-to-back jobs: the earliest next `start` is accepted in the cycle after `done`.

## Test plan
Use size=4 and drain_lat=8 throughout.
- Full job, N=3, `reuse_weights`=0, start at cycle 0:
  - `wt_rd_en` in cycles 1-4 with addr 3,2,1,0; `sa_control` in cycles 2-5.
  - `act_rd_en` in cycles 5-7 with addr 0,1,2.
  - `out_valid` in cycles 14-16 with `out_addr` 0,1,2.
  - `done` at cycle 17; `busy` in cycles 1-16; `weights_loaded` rises at cycle 6.
- Reuse, N=3, `weights_loaded`=1: no `wt_rd_en` and no `sa_control`; `act_rd_en` in cycles 1-3; `out_valid` in cycles 10-12; `done` at cycle 13.
- Forced load: `reuse_weights`=1 right after reset. The full load sequence runs exactly as in the first scenario.
- N=0:
  - Load: `sa_control` in cycles 2-5 and `done` at cycle 6, with no `act_rd_en` or `out_valid`.
  - Reuse: `done` at cycle 1 and `busy` stays 0.
- `start` pulsed at cycles 3 and 10 of a running job: both are ignored, and the output trace is identical to the first scenario.
- Reset asserted at cycle 6 of a full job:
  - From cycle 7, all outputs are 0 and `weights_loaded`=0.
  - A new start with `reuse_weights`=1 at cycle 9 performs a full load.
  - Reset and start together in one cycle: no job starts.
